// File: rtl/pwm_duty_capture.sv
// Three-phase PWM duty capture: per-window high-time count and
// sequential restoring divide back to 16-bit signed references.
module pwm_duty_capture #(
  parameter int CNT_W       = 20,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PERIOD  = 4
) (
  input  logic             CLK,
  input  logic             ARESETN,
  input  logic             PWM_U_IN,
  input  logic             PWM_V_IN,
  input  logic             PWM_W_IN,
  input  logic             WIN_START,
  input  logic             CLR_ERR,
  output logic [15:0]      DUTY_U,
  output logic [15:0]      DUTY_V,
  output logic [15:0]      DUTY_W,
  output logic [CNT_W-1:0] PERIOD,
  output logic             DATA_VALID,
  output logic             BUSY,
  output logic             OVERRUN,
  output logic             OVERRANGE
);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] MAX  = '1;
  localparam logic [CNT_W-1:0] MINP = CNT_W'(MIN_PERIOD);

  state_t state, state_n;

  logic [2:0]       sync [SYNC_STAGES];
  logic [2:0]       sx;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] hcnt [3];
  logic [CNT_W-1:0] lp;
  logic [CNT_W-1:0] lh [3];
  logic             armed;
  logic             go;
  logic             bad;
  logic             accept;
  logic             drop;
  logic             set_rng;

  logic [1:0]       ph;
  logic [4:0]       cnt;
  logic [CNT_W:0]   rem;
  logic [CNT_W:0]   r2;
  logic [CNT_W:0]   diff;
  logic             ge;
  logic [14:0]      quo;
  logic [15:0]      qn;
  logic [15:0]      res [3];
  logic [CNT_W-1:0] hsel;
  logic             last;

  assign sx = sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
    end else begin
      sync[0] <= {PWM_W_IN, PWM_V_IN, PWM_U_IN};
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pcnt <= '0;
      for (int i = 0; i < 3; i++) hcnt[i] <= '0;
    end else if (WIN_START) begin
      pcnt <= CNT_W'(1);
      for (int i = 0; i < 3; i++) hcnt[i] <= CNT_W'(sx[i]);
    end else begin
      pcnt <= (pcnt == MAX) ? pcnt : pcnt + CNT_W'(1);
      for (int i = 0; i < 3; i++)
        hcnt[i] <= (hcnt[i] == MAX) ? hcnt[i] : hcnt[i] + CNT_W'(sx[i]);
    end
  end

  // go covers the one cycle between latching and the FSM leaving IDLE
  always_comb begin
    bad     = (pcnt == MAX) || (pcnt < MINP);
    accept  = WIN_START && armed && !bad && state == IDLE && !go;
    drop    = WIN_START && armed && !bad && (state != IDLE || go);
    set_rng = WIN_START && armed && bad;
  end

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      armed     <= 1'b0;
      go        <= 1'b0;
      lp        <= '0;
      for (int i = 0; i < 3; i++) lh[i] <= '0;
      OVERRUN   <= 1'b0;
      OVERRANGE <= 1'b0;
    end else begin
      armed <= armed | WIN_START;
      go    <= accept;
      if (accept) begin
        lp <= pcnt;
        for (int i = 0; i < 3; i++) lh[i] <= hcnt[i];
      end
      if (drop) OVERRUN <= 1'b1;
      else if (CLR_ERR) OVERRUN <= 1'b0;
      if (set_rng) OVERRANGE <= 1'b1;
      else if (CLR_ERR) OVERRANGE <= 1'b0;
    end
  end

  always_comb begin
    unique case (ph)
      2'd0:    hsel = lh[0];
      2'd1:    hsel = lh[1];
      default: hsel = lh[2];
    endcase
  end

  // rem[CNT_W] stands in for the shifted-out bit of 2*rem
  assign r2   = {rem[CNT_W-1:0], 1'b0};
  assign ge   = rem[CNT_W] || (r2 >= {1'b0, lp});
  assign diff = r2 - {1'b0, lp};
  assign qn   = {quo, ge};
  assign last = (state == DIV) && (ph == 2'd2) && (cnt == 5'd16);

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (go) state_n = DIV;
      DIV:     if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ph  <= '0;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      for (int i = 0; i < 3; i++) res[i] <= '0;
    end else if (state != DIV) begin
      ph  <= '0;
      cnt <= '0;
    end else if (cnt == 5'd0) begin
      rem <= {1'b0, hsel};
      quo <= '0;
      cnt <= 5'd1;
    end else begin
      rem <= ge ? diff : r2;
      quo <= qn[14:0];
      if (cnt == 5'd16) begin
        cnt <= '0;
        ph  <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
        unique case (ph)
          2'd0:    res[0] <= (hsel >= lp) ? 16'hFFFF : qn;
          2'd1:    res[1] <= (hsel >= lp) ? 16'hFFFF : qn;
          default: res[2] <= (hsel >= lp) ? 16'hFFFF : qn;
        endcase
      end else begin
        cnt <= cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      DATA_VALID <= 1'b0;
      DUTY_U     <= '0;
      DUTY_V     <= '0;
      DUTY_W     <= '0;
      PERIOD     <= '0;
    end else begin
      DATA_VALID <= (state == DONE);
      if (state == DONE) begin
        DUTY_U <= res[0] ^ 16'h8000;
        DUTY_V <= res[1] ^ 16'h8000;
        DUTY_W <= res[2] ^ 16'h8000;
        PERIOD <= lp;
      end
    end
  end

  assign BUSY = (state != IDLE);

endmodule
